calc_display_rx: RTL and testbench
==================================

Name: calc_display_rx

Overview:
Receiving end of the calculator's digit-serial display interface (status, data, pos).
- Captures the eight BCD digit nibbles the calculator streams out while busy.
- Commits a complete frame into a display buffer.
- Drives an 8-digit multiplexed, active-low 7-segment display.
- Flags the calculator's error status sticky, showing "Erro" until reset.

Parameters:
REFRESH_DIV, 50000, clock cycles each digit stays lit during scanning (min 2)
LEAD_BLANK, 1, 1 = blank leading zeros on digits 7..1; 0 = show all digits

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clock edge)
status  input  2  calculator status: 00 error, 01 busy, 10 ready
data  input  4  BCD digit nibble for the slot given by pos
pos  input  4  digit slot 0..7; any value 8..15 marks end of frame
an  output  8  digit enables, active-low, bit i = digit i (0 = rightmost)
seg  output  7  segments {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point, active-low, always 1 (off)
frame_valid  output  1  one-cycle pulse when a frame is committed
err  output  1  sticky error flag

Behaviour:
Reset (reset==0 at a rising edge), values after that edge:
- Outputs: an=8'hFF, seg=7'h7F, dp=1, frame_valid=0, err=0.
- Internal: shadow[7:0]=0, seen=8'h00, buffer[7:0]=0, refresh counter=0, scan index=0.
- Reset mid-frame discards all partial capture.

Capture, every cycle:
- Condition: pos<=7 and status!=2'b10.
- Action: shadow[pos]<=data, seen[pos]<=1.
- A repeated slot overwrites; last write wins.
- data values 10..15 are stored as-is and later decode to blank.

Commit, every cycle in which pos>=8:
- If seen==8'hFF: buffer<=shadow, and frame_valid=1 on the next cycle for exactly one cycle.
- If seen!=8'hFF: frame is dropped, buffer is unchanged, no pulse.
- seen is cleared in both cases.
- pos held >=8 for several cycles: only the first such cycle can commit, since seen is already clear on later cycles.
- Capture and commit are mutually exclusive because pos values differ.

Error:
- Any sampled status==2'b00 sets err<=1, held until reset.
- While err==1: capture and commit are inhibited.
- Display shows digit3=E, digit2=r, digit1=r, digit0=o; digits 7..4 are blank.

Digit value per slot i (err==0):
- Source is buffer[i].
- If LEAD_BLANK==1, i>0, and buffer[7..i] are all 0, slot i is blank.
- Digit 0 is never leading-blanked.

Segment codes, seg {g..a}, active-low:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- E=0000110, r=0101111, o=0100011, blank=1111111.

Scanning:
- Refresh counter counts 0..REFRESH_DIV-1, then wraps to 0.
- On each wrap, the scan index increments mod 8 (7 -> 0).
- an and seg are registered. They update one cycle after the scan index changes or the buffer/err changes.
- an = all 1s except bit[scan index]=0.
- After reset: an stays 8'hFF until the first counter wrap. At that edge the scan index goes 0 -> 1. From the following cycle an=8'hFD, and the first digit lit is digit 1 (digit 0 is first lit after wrap from 7).
- Buffer commit while scanning: the new value appears on the currently lit digit one cycle after commit, with no scan restart.

Test Plan:
1. reset=0 for 2 cycles, then 1 -> an=8'hFF, seg=7'h7F, dp=1, frame_valid=0, err=0. With REFRESH_DIV=4, an=8'hFD from cycle 5 after release.
2. REFRESH_DIV=4, LEAD_BLANK=1, status=01; send pos0..7 with data 3,2,1,0,0,0,0,0, then pos=8 with status=10.
   - frame_valid=1 for exactly one cycle, the cycle after pos=8.
   - Scanning shows an=FE seg=0110000, an=FD seg=0100100, an=FB seg=1111001.
   - an=F7..7F show seg=7F.
3. After test 2, send pos0..4 only, then pos=8 -> no frame_valid, display still shows 123. Next full frame of 9 in all slots -> shows 99999999.
4. Inject status=00 for one cycle, then a full frame -> err=1 permanently, no frame_valid. Digits 3..0 show 0000110, 0101111, 0101111, 0100011; digits 7..4 show 7F.
5. REFRESH_DIV=4 -> an steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, one step every 4 cycles, wrapping 7 -> 0.
6. Send pos0..5, assert reset=0 for 1 cycle, send pos6, pos7, then pos=8 -> no commit, buffer=0, display shows only "0" on digit 0.

Source files
------------

// File: rtl/calc_display_rx.sv
// Receiver for the calculator's digit-serial display link: captures BCD digit frames,
// commits complete frames to a buffer and scans them onto an 8-digit active-low 7-seg display.
module calc_display_rx #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned LEAD_BLANK  = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_valid,
  output logic       err
);

  localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

  localparam logic [1:0] StatError = 2'b00;
  localparam logic [1:0] StatReady = 2'b10;

  localparam logic [6:0] SegE     = 7'b0000110;
  localparam logic [6:0] SegR     = 7'b0101111;
  localparam logic [6:0] SegO     = 7'b0100011;
  localparam logic [6:0] SegBlank = 7'b1111111;

  logic [7:0][3:0] shadow_q, shadow_d;
  logic [7:0][3:0] buffer_q, buffer_d;
  logic [7:0]      seen_q, seen_d;
  logic            err_q, err_d;
  logic            fv_q, fv_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic            scan_on_q, scan_on_d;
  logic [7:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic            wrap;
  logic            nonzero_above;
  logic            blank_lead;
  logic [6:0]      digit_seg;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SegBlank;
    endcase
    return s;
  endfunction

  // Frame capture, commit and sticky error
  always_comb begin
    shadow_d = shadow_q;
    buffer_d = buffer_q;
    seen_d   = seen_q;
    err_d    = err_q;
    fv_d     = 1'b0;

    if (!err_q) begin
      if (!pos[3]) begin
        if (status != StatReady) begin
          shadow_d[pos[2:0]] = data;
          seen_d[pos[2:0]]   = 1'b1;
        end
      end else begin
        // Only the first end-of-frame cycle can commit; seen is clear afterwards.
        if (seen_q == 8'hFF) begin
          buffer_d = shadow_q;
          fv_d     = 1'b1;
        end
        seen_d = 8'h00;
      end
    end

    if (status == StatError) begin
      err_d = 1'b1;
    end
  end

  // Refresh counter and scan index
  always_comb begin
    wrap      = (cnt_q == CntMax);
    cnt_d     = wrap ? '0 : cnt_q + CntW'(1);
    idx_d     = wrap ? idx_q + 3'd1 : idx_q;
    scan_on_d = scan_on_q | wrap;
  end

  // Segment pattern for the digit currently selected by the scan index
  always_comb begin
    nonzero_above = 1'b0;
    for (int j = 0; j < 8; j++) begin
      if ((j >= int'(idx_q)) && (buffer_q[j] != 4'd0)) begin
        nonzero_above = 1'b1;
      end
    end
    blank_lead = (LEAD_BLANK != 0) && (idx_q != 3'd0) && !nonzero_above;

    if (err_q) begin
      case (idx_q)
        3'd3:    digit_seg = SegE;
        3'd2:    digit_seg = SegR;
        3'd1:    digit_seg = SegR;
        3'd0:    digit_seg = SegO;
        default: digit_seg = SegBlank;
      endcase
    end else if (blank_lead) begin
      digit_seg = SegBlank;
    end else begin
      digit_seg = seg_decode(buffer_q[idx_q]);
    end

    // Display stays dark until the first refresh wrap.
    an_d  = scan_on_q ? ~(8'd1 << idx_q) : 8'hFF;
    seg_d = scan_on_q ? digit_seg : SegBlank;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      shadow_q  <= '0;
      buffer_q  <= '0;
      seen_q    <= 8'h00;
      err_q     <= 1'b0;
      fv_q      <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      scan_on_q <= 1'b0;
      an_q      <= 8'hFF;
      seg_q     <= SegBlank;
    end else begin
      shadow_q  <= shadow_d;
      buffer_q  <= buffer_d;
      seen_q    <= seen_d;
      err_q     <= err_d;
      fv_q      <= fv_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      scan_on_q <= scan_on_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = 1'b1;
  assign frame_valid = fv_q;
  assign err         = err_q;

endmodule

// File: tb/tb_calc_display_rx.sv
// Bench for calc_display_rx: frames are driven digit by digit, expected commit pulses and
// display images are queued at send time and compared once the DUT has scanned them out.
module tb_calc_display_rx;

  localparam int unsigned RD = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SE = 7'b0000110;
  localparam logic [6:0] SR = 7'b0101111;
  localparam logic [6:0] SO = 7'b0100011;
  localparam logic [6:0] SB = 7'b1111111;

  typedef logic [7:0][6:0] img_t;
  typedef logic [7:0][3:0] digits_t;
  typedef struct packed {
    logic [1:0] pulses;
    img_t       img;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_valid;
  logic       err;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  calc_display_rx #(
    .REFRESH_DIV(RD),
    .LEAD_BLANK (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .status     (status),
    .data       (data),
    .pos        (pos),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_valid(frame_valid),
    .err        (err)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [1:0] st, input logic [3:0] p, input logic [3:0] d);
    status = st;
    pos    = p;
    data   = d;
    @(negedge clock);
  endtask

  // Sends the masked slots, then one end-of-frame cycle, and counts commit pulses.
  task automatic send(input digits_t d, input logic [7:0] mask, output int pulses,
                      output int first);
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) drive(2'b01, 4'(i), d[i]);
    end
    status = 2'b10;
    pos    = 4'h8;
    data   = 4'h0;
    pulses = 0;
    first  = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clock);
      if (frame_valid) begin
        pulses++;
        if (first < 0) first = k;
      end
      pos = 4'hF;
    end
  endtask

  task automatic capture(output img_t got);
    got = 'x;
    for (int k = 0; k < 48; k++) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        if (an == ~(8'd1 << i)) got[i] = seg;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    reset  = 1'b0;
    status = 2'b10;
    pos    = 4'hF;
    data   = 4'h0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    checks++; if (an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected ff", an); end
    checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", seg); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", dp); end
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    cyc = 0;
    while (an === 8'hFF && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (cyc != 5) begin errors++; $display("FAIL first_scan_cycle: got %0d expected 5", cyc); end
    checks++; if (an !== 8'hFD) begin errors++; $display("FAIL first_scan_an: got %h expected fd", an); end
  endtask

  task automatic test_frame();
    digits_t d;
    img_t    e, got;
    exp_t    x;
    int      pulses, first;
    d = '0;
    d[0] = 4'd3; d[1] = 4'd2; d[2] = 4'd1;
    e = {8{SB}};
    e[0] = S3; e[1] = S2; e[2] = S1;
    exp_q.push_back('{pulses: 2'd1, img: e});
    send(d, 8'hFF, pulses, first);
    x = exp_q.pop_front();
    checks++;
    if (pulses != int'(x.pulses)) begin
      errors++; $display("FAIL frame_pulses: got %0d expected %0d", pulses, x.pulses);
    end
    checks++;
    if (first != 1) begin errors++; $display("FAIL frame_pulse_cycle: got %0d expected 1", first); end
    capture(got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== x.img[i]) begin
        errors++; $display("FAIL frame_digit%0d: got %b expected %b", i, got[i], x.img[i]);
      end
    end
  endtask

  task automatic test_drop_then_full();
    digits_t d;
    img_t    e, got;
    exp_t    x;
    int      pulses, first;
    d = {8{4'd7}};
    e = {8{SB}};
    e[0] = S3; e[1] = S2; e[2] = S1;
    exp_q.push_back('{pulses: 2'd0, img: e});
    send(d, 8'h1F, pulses, first);
    x = exp_q.pop_front();
    checks++;
    if (pulses != int'(x.pulses)) begin
      errors++; $display("FAIL drop_pulses: got %0d expected %0d", pulses, x.pulses);
    end
    capture(got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== x.img[i]) begin
        errors++; $display("FAIL drop_digit%0d: got %b expected %b", i, got[i], x.img[i]);
      end
    end
    d = {8{4'd9}};
    exp_q.push_back('{pulses: 2'd1, img: {8{S9}}});
    send(d, 8'hFF, pulses, first);
    x = exp_q.pop_front();
    checks++;
    if (pulses != int'(x.pulses)) begin
      errors++; $display("FAIL full9_pulses: got %0d expected %0d", pulses, x.pulses);
    end
    capture(got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== x.img[i]) begin
        errors++; $display("FAIL full9_digit%0d: got %b expected %b", i, got[i], x.img[i]);
      end
    end
  endtask

  task automatic test_error();
    digits_t d;
    img_t    e, got;
    exp_t    x;
    int      pulses, first;
    drive(2'b00, 4'hF, 4'h0);
    d = {8{4'd5}};
    e = {8{SB}};
    e[3] = SE; e[2] = SR; e[1] = SR; e[0] = SO;
    exp_q.push_back('{pulses: 2'd0, img: e});
    send(d, 8'hFF, pulses, first);
    x = exp_q.pop_front();
    checks++;
    if (pulses != int'(x.pulses)) begin
      errors++; $display("FAIL err_pulses: got %0d expected %0d", pulses, x.pulses);
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
    capture(got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== x.img[i]) begin
        errors++; $display("FAIL err_digit%0d: got %b expected %b", i, got[i], x.img[i]);
      end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_scan();
    logic [7:0] prev, want;
    int         dwell;
    prev  = an;
    dwell = 0;
    while (an === prev && dwell < 12) begin
      @(negedge clock);
      dwell++;
    end
    for (int s = 0; s < 9; s++) begin
      prev  = an;
      want  = {prev[6:0], prev[7]};
      dwell = 0;
      do begin
        @(negedge clock);
        dwell++;
      end while (an === prev && dwell < 12);
      checks++;
      if (dwell != int'(RD)) begin
        errors++; $display("FAIL scan_dwell%0d: got %0d expected %0d", s, dwell, RD);
      end
      checks++;
      if (an !== want) begin
        errors++; $display("FAIL scan_step%0d: got %h expected %h", s, an, want);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    digits_t d;
    img_t    e, got;
    exp_t    x;
    int      pulses, first;
    for (int i = 0; i < 6; i++) drive(2'b01, 4'(i), 4'd6);
    reset = 1'b0;
    drive(2'b10, 4'hF, 4'h0);
    reset = 1'b1;
    d = {8{4'd6}};
    e = {8{SB}};
    e[0] = S0;
    exp_q.push_back('{pulses: 2'd0, img: e});
    send(d, 8'hC0, pulses, first);
    x = exp_q.pop_front();
    checks++;
    if (pulses != int'(x.pulses)) begin
      errors++; $display("FAIL midrst_pulses: got %0d expected %0d", pulses, x.pulses);
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b expected 0", err); end
    capture(got);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (got[i] !== x.img[i]) begin
        errors++; $display("FAIL midrst_digit%0d: got %b expected %b", i, got[i], x.img[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_drop_then_full();
    test_error();
    test_scan();
    test_reset_mid_frame();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
